// File: rtl/bcd_pkg.sv
// Shared constants for the BCD display path: active-high gfedcba segment
// patterns for 0-9, the error glyph 'E', a blank pattern and the BCD limit.
package bcd_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_MAX   = 4'd9;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational 4-bit digit to active-high gfedcba segment decoder.
// Codes above 9 are not BCD and render as 'E'.
module bcd_to_seg7
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_E;
    case (digit_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Time-multiplexed 7-segment driver for a packed BCD word with a one-entry,
// frame-synchronised pending buffer. LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_display_driver
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_DIV    = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [4*NUM_DIGITS-1:0] in_digits,
  output logic                    in_ready,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    err
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_POL  = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    err_q, err_d;

  logic                    last_div, last_digit, frame_end;
  logic [3:0]              digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   digit_bad;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [3:0]              cur_digit;
  logic [6:0]              dec_seg;

  assign last_div   = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
  assign last_digit = (digit_idx_q == IDX_W'(NUM_DIGITS - 1));
  assign frame_end  = last_div && last_digit;
  assign in_ready   = !pend_vld_q;

  always_comb begin
    div_cnt_d   = last_div ? '0 : div_cnt_q + DIV_W'(1);
    digit_idx_d = digit_idx_q;
    if (last_div) begin
      digit_idx_d = last_digit ? '0 : digit_idx_q + IDX_W'(1);
    end
  end

  // The shown word only changes on frame_end, so a frame never mixes two words.
  always_comb begin
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (frame_end) begin
      if (pend_vld_q) begin
        disp_d     = pend_q;
        pend_vld_d = 1'b0;
      end else if (in_valid) begin
        disp_d = in_digits;
      end
    end else if (in_valid && !pend_vld_q) begin
      pend_d     = in_digits;
      pend_vld_d = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit_arr[gi] = disp_q[4*gi +: 4];
    assign digit_bad[gi] = (disp_q[4*gi +: 4] > BCD_MAX);
    assign an_onehot[gi] = (digit_idx_q == IDX_W'(gi));
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the MS digit down; the run of zeros ends at the first non-zero.
  logic zero_run;
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run && (digit_arr[k] == 4'd0);
      blank_mask[k] = zero_run && (k != 0);
    end
  end
`else
  assign blank_mask = '0;
`endif

  assign cur_digit = digit_arr[digit_idx_q];

  bcd_to_seg7 u_dec (
    .digit_i (cur_digit),
    .seg_o   (dec_seg)
  );

  always_comb begin
    seg_d = (blank_mask[digit_idx_q] ? SEG_BLANK : dec_seg) ^ SEG_POL;
    an_d  = an_onehot ^ AN_POL;
    err_d = |digit_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      seg_q       <= SEG_BLANK ^ SEG_POL;
      an_q        <= AN_POL;
      err_q       <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      err_q       <= err_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed bench for bcd_display_driver (2 digits, divide-by-4, active-high)
// with a cycle-indexed reference model and hand-computed spot checks.
module tb_bcd_display_driver;

  localparam int ND    = 2;
  localparam int RD    = 4;
  localparam int FRAME = ND * RD;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h00;
`else
  localparam logic [6:0] LZ_SEG = 7'h3F;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_digits;
  logic       in_ready;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int passed = 0;
  int total  = 0;

  bcd_display_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_digits (in_digits),
    .in_ready  (in_ready),
    .seg       (seg),
    .an        (an),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int         t;          // cycles since reset release
  logic [7:0] m_disp;
  logic [7:0] m_pend [$];
  logic [6:0] e_seg;
  logic [1:0] e_an;
  logic       e_err;
  bit         model_ok = 0;

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  function automatic bit ref_blank(input logic [7:0] w, input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 0) return 0;
    for (int k = slot; k < ND; k++)
      if (((w >> (4 * k)) & 8'hF) != 0) return 0;
    return 1;
`else
    return (w == 8'hFF) && (slot < 0);
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t = 0;
      m_disp = 8'h00;
      m_pend.delete();
      e_an = 2'b00; e_seg = 7'h00; e_err = 1'b0;
    end else begin
      int slot, d;
      bit fe, bad;
      slot  = (t / RD) % ND;
      fe    = (t % FRAME) == FRAME - 1;
      d     = int'((m_disp >> (4 * slot)) & 8'hF);
      e_an  = 2'(1 << slot);
      e_seg = ref_blank(m_disp, slot) ? 7'h00 : ref_seg(d);
      bad = 0;
      for (int k = 0; k < ND; k++)
        if (((m_disp >> (4 * k)) & 8'hF) > 9) bad = 1;
      e_err = bad;
      if (fe) begin
        if (m_pend.size() != 0) m_disp = m_pend.pop_front();
        else if (in_valid) m_disp = in_digits;
      end else if (in_valid && m_pend.size() == 0) begin
        m_pend.push_back(in_digits);
      end
      t++;
    end
    model_ok = 1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc_seg", int'(seg), int'(e_seg));
      chk("cyc_an", int'(an), int'(e_an));
      chk("cyc_err", int'(err), int'(e_err));
      chk("cyc_ready", int'(in_ready), int'(m_pend.size() == 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] w);
    int n;
    in_digits = w;
    in_valid  = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (in_ready) break;
      if (n > 40) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("xfer %02h accepted, frame phase %0d", w, (t - 1) % FRAME);
  endtask

  task automatic wait_phase(input int p);
    while ((t % FRAME) != p) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    repeat (2 * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic check_digit(input string name, input logic [1:0] an_val, input logic [6:0] exp_seg);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an != an_val && n < 3 * FRAME);
    chk({name, "_an"}, int'(an), int'(an_val));
    chk(name, int'(seg), int'(exp_seg));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_digits = 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk("rst_an", int'(an), 0);
    chk("rst_seg", int'(seg), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: word offered in the first cycle after reset
    send(8'h15);
    @(negedge clk);
    chk("s1_ready_low", int'(in_ready), 0);
    settle();
    check_digit("s1_d0", 2'b01, 7'h6D);
    check_digit("s1_d1", 2'b10, 7'h06);
    chk("s1_err", int'(err), 0);

    // 2: second word held off while the first is pending
    wait_phase(2);
    send(8'h12);
    in_digits = 8'h34;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("s2_ready_busy", int'(in_ready), 0);
    send(8'h34);
    chk("s2_accept_phase", (t - 1) % FRAME, 0);
    check_digit("s2_12_d0", 2'b01, 7'h5B);
    check_digit("s2_12_d1", 2'b10, 7'h06);
    check_digit("s2_34_d0", 2'b01, 7'h66);
    check_digit("s2_34_d1", 2'b10, 7'h4F);

    // 3: bypass exactly at frame end
    wait_phase(FRAME - 1);
    in_digits = 8'h99;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("s3_ready_fe", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("s3_ready_stays", int'(in_ready), 1);
    check_digit("s3_d0", 2'b01, 7'h6F);
    check_digit("s3_d1", 2'b10, 7'h6F);

    // 4: non-BCD digit, then recovery
    send(8'h1A);
    settle();
    check_digit("s4_d0", 2'b01, 7'h79);
    check_digit("s4_d1", 2'b10, 7'h06);
    chk("s4_err", int'(err), 1);
    send(8'h42);
    settle();
    chk("s4_err_clear", int'(err), 0);
    check_digit("s4_42_d0", 2'b01, 7'h5B);

    // 5: leading zeros
    send(8'h07);
    settle();
    check_digit("s5_07_d0", 2'b01, 7'h07);
    check_digit("s5_07_d1", 2'b10, LZ_SEG);
    send(8'h00);
    settle();
    check_digit("s5_00_d0", 2'b01, 7'h3F);
    check_digit("s5_00_d1", 2'b10, LZ_SEG);

    // 6: reset while a word is pending
    send(8'h08);
    settle();
    wait_phase(2);
    send(8'h55);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("s6_an", int'(an), 0);
    chk("s6_seg", int'(seg), 0);
    chk("s6_ready", int'(in_ready), 1);
    rst = 1'b0;
    begin
      bit seen = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
        @(negedge clk);
        if (seg == 7'h6D) seen = 1;
      end
      chk("s6_pend_never_shown", int'(seen), 0);
    end
    check_digit("s6_d0", 2'b01, 7'h3F);
    check_digit("s6_d1", 2'b10, LZ_SEG);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
